// File: rtl/nn_sc_pkg.sv
// nn_sc_pkg: shared state encoding and frame-length helper for the stochastic frame counter
package nn_sc_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} sc_state_e;
  localparam int DEF_W = 8;
  function automatic int unsigned frame_len(input int unsigned w);
    return 32'd1 << w;
  endfunction
endpackage

// File: rtl/nn_sc_frame_counter_bitcount.sv
// SC_BITCOUNT: N-bit accumulator; ports clk/rst, clr (zero), en (count), dn (down), cnt_q (value), cnt_d (next value)
module SC_BITCOUNT #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         dn,
  output logic [N-1:0] cnt_q,
  output logic [N-1:0] cnt_d
);
  always_comb cnt_d = clr ? '0 : en ? (dn ? cnt_q - 1'b1 : cnt_q + 1'b1) : cnt_q;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/nn_sc_frame_counter.sv
// nn_sc_frame_counter: counts a (unsigned) and signed z over 2^W cycles; ports CLK, INIT, START, a, z, SIGN_z, ACK in; A_COUNT, Z_COUNT, VALID, BUSY out
module nn_sc_frame_counter
  import nn_sc_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         CLK,
  input  logic         INIT,
  input  logic         START,
  input  logic         a,
  input  logic         z,
  input  logic         SIGN_z,
  input  logic         ACK,
  output logic [W:0]   A_COUNT,
  output logic [W+1:0] Z_COUNT,
  output logic         VALID,
  output logic         BUSY
);
  sc_state_e    state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W:0]   a_count_q, a_count_d, a_acc, a_nxt;
  logic [W+1:0] z_count_q, z_count_d, z_acc, z_nxt;
  logic         valid_q, valid_d, busy_q, busy_d;
  logic         run, term, ack_h, go;
  always_comb begin
    run       = state_q == RUN;
    term      = run && cnt_q == '1;
    ack_h     = state_q == HOLD && ACK;
    go        = START && (state_q == IDLE || ack_h);
    state_d   = go ? RUN : term ? HOLD : ack_h ? IDLE : state_q;
    cnt_d     = go ? '0 : run ? cnt_q + 1'b1 : cnt_q;
    // next-accumulator values already include this edge's (final) sample
    a_count_d = term ? a_nxt : a_count_q;
    z_count_d = term ? z_nxt : z_count_q;
    valid_d   = term ? 1'b1 : ack_h ? 1'b0 : valid_q;
    busy_d    = state_d == RUN;
  end
  always_ff @(posedge CLK)
    if (INIT) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_count_q <= '0;
      z_count_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_count_q <= a_count_d;
      z_count_q <= z_count_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  SC_BITCOUNT #(.N(W + 1)) u_a (
    .clk(CLK), .rst(INIT), .clr(go), .en(run && a), .dn(1'b0), .cnt_q(a_acc), .cnt_d(a_nxt)
  );
  SC_BITCOUNT #(.N(W + 2)) u_z (
    .clk(CLK), .rst(INIT), .clr(go), .en(run && z), .dn(SIGN_z), .cnt_q(z_acc), .cnt_d(z_nxt)
  );
  assign A_COUNT = a_count_q;
  assign Z_COUNT = z_count_q;
  assign VALID   = valid_q;
  assign BUSY    = busy_q;
endmodule

// File: doc/nn_sc_frame_counter.md
# nn_sc_frame_counter

Stochastic-to-binary converter that sits directly downstream of a soft convolution node. Over a fixed frame of 2^W clock cycles it counts the node's activation bitstream `a_out`. In parallel it keeps a signed count of the pre-activation stream `z`/`SIGN_z`. At the end of the frame it presents both counts as binary words under a VALID/ACK handshake. This closes the stochastic datapath for readout, debug and layer-to-layer re-encoding.

## Interface
- `W`, default 8: frame length exponent; one frame is 2^W samples.
- `CLK`  in  1  system clock; all logic on rising edge.
- `INIT`  in  1  reset, synchronous, active-high.
- `START`  in  1  single-cycle pulse requesting a new frame.
- `a`  in  1  activation bitstream, from the node's `a_out`.
- `z`  in  1  magnitude bitstream of the node's pre-activation.
- `SIGN_z`  in  1  sign of `z` for the current cycle; 1 means negative.
- `ACK`  in  1  consumer accepts the presented result.
- `A_COUNT`  out  W+1  unsigned count of `a`=1 samples in the last frame, range 0..2^W.
- `Z_COUNT`  out  W+2  two's-complement net count of `z`, range -2^W..+2^W.
- `VALID`  out  1  result on `A_COUNT`/`Z_COUNT` is new and unacknowledged.
- `BUSY`  out  1  a frame is being sampled.

## Operation
- States:
  - IDLE: no sampling.
  - RUN: sampling the streams.
  - HOLD: result presented, VALID=1.
- IDLE -> RUN on `START`=1.
  - Internal accumulators and the sample counter clear in the same edge.
- In RUN, the block samples exactly once per cycle and spends exactly 2^W cycles in RUN.
  - `a`=1 increments the A accumulator.
  - `z`=1 with `SIGN_z`=0 adds +1 to the Z accumulator.
  - `z`=1 with `SIGN_z`=1 adds -1.
  - `z`=0 leaves the Z accumulator unchanged; `SIGN_z` is ignored.
- After the 2^W-th sample the state goes to HOLD.
  - On that edge the final accumulator values, including the last sample, load into the `A_COUNT`/`Z_COUNT` output registers and VALID is set.
- HOLD -> IDLE on `ACK`=1.
  - If `ACK` and `START` are both 1 in the same HOLD cycle, go directly HOLD -> RUN. This gives back-to-back frames with no gap cycle.
- `START` while in RUN is ignored; the current frame completes unchanged.
- `START` while in HOLD with `ACK`=0 is ignored and not remembered.
- `ACK` outside HOLD is ignored.
- Output registers change only when a frame completes or on INIT.
  - They hold their value through IDLE, RUN and HOLD.
- No overflow is possible: the accumulators are sized to the maximum range, so there is no saturation logic.
- INIT=1 at any time, including mid-frame:
  - next state IDLE;
  - accumulators, sample counter, `A_COUNT`, `Z_COUNT`, VALID and BUSY all go to 0;
  - any partial frame is discarded.
- INIT has priority over START and ACK.

## Timing
- Reset values: `A_COUNT`=0, `Z_COUNT`=0, VALID=0, BUSY=0, state IDLE.
- With `START` sampled high at edge t:
  - BUSY=1 from t+1 through t+2^W.
  - Samples are taken at edges t+1 .. t+2^W.
  - VALID=1 and the new counts are visible after edge t+2^W.
  - Latency from START to VALID is therefore 2^W+1 cycles.
- BUSY is a registered copy of (state==RUN).
- VALID is registered and drops on the edge that samples `ACK`=1.
- In a back-to-back transition (HOLD with ACK+START), VALID falls and BUSY rises on the same edge. The old result stays on the outputs until the new frame completes.
- The sample counter is W bits and wraps from 2^W-1 to 0 on the terminal sample; the terminal condition is count==2^W-1 while in RUN.

## Structure
- Shared package `nn_sc_pkg` holds:
  - the 2-bit state encoding (IDLE=0, RUN=1, HOLD=2);
  - the frame-length helper localparam.
- One sub-module, `SC_BITCOUNT`.
  - It is a parameterised-width accumulator with clear, enable and up/down inputs.
  - It is instantiated twice: unsigned with up-only for `a`, signed with up/down for `z`.
- The FSM, sample counter and output registers live in the top module.

## Test plan
- W=4. INIT, then START with `a`=1, `z`=1, `SIGN_z`=0 held constant -> VALID rises 17 cycles after START, `A_COUNT`=16, `Z_COUNT`=+16.
- W=4, `a` alternating 1,0 starting at 1; `z`=1 with `SIGN_z` alternating 0,1 -> `A_COUNT`=8, `Z_COUNT`=0.
- W=4, `a`=0, `z`=1, `SIGN_z`=1 constant -> `A_COUNT`=0, `Z_COUNT`=-16 (6'b110000).
- Hold ACK=0 for 20 cycles after VALID and pulse START twice -> VALID stays 1, BUSY stays 0, outputs unchanged. Then assert ACK and START together -> next edge VALID=0, BUSY=1, and the second result arrives 16 cycles later.
- Assert INIT on the 7th RUN cycle -> next edge all outputs 0, BUSY=0. A following START with `a`=1 gives `A_COUNT`=16, proving no residue from the aborted frame.
- Pulse START on the 5th RUN cycle -> ignored; VALID still arrives exactly 17 cycles after the original START with the correct count.
